// File: rtl/sc_chain_target.sv
// sc_chain_target
// ---------------
// Chip-side end of the serial scan-chain configuration link. The host's scan
// master drives SC_clk / SC_data / SC_load. This block oversamples them on the
// FPGA system clock, shifts in a DATA_LENG-bit config frame LSB-first, and
// latches it in parallel when SC_load rises. It then returns a parallel status
// word serially on data_out, MSB first, while SC_load is high. It is used as a
// loopback target / chip emulator for bring-up of the master and host software.
//
// Ports
//   clki       system clock
//   rst_n      asynchronous active-low reset
//   SC_clk     scan clock from the master (asynchronous to clki)
//   SC_data    serial config bit, changes on SC_clk falling edge
//   SC_load    load / readback phase strobe
//   status_in  parallel status word, captured when a full frame has arrived
//   data_out   serial readback bit, sampled by the master on SC_clk fall
//   cfg_out    last latched config word
//   cfg_valid  one-clki pulse when cfg_out updates
//   frame_err  set when SC_load rose before a full frame was shifted in
//   busy       high in any state other than IDLE
`timescale 1ns/1ps

module sc_chain_target #(
  parameter int DATA_LENG    = 20,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 3000000
) (
  input  logic                 clki,
  input  logic                 rst_n,
  input  logic                 SC_clk,
  input  logic                 SC_data,
  input  logic                 SC_load,
  input  logic [DATA_LENG-1:0] status_in,
  output logic                 data_out,
  output logic [DATA_LENG-1:0] cfg_out,
  output logic                 cfg_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_LENG + 1);
  localparam int TO_W  = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_LENG);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LENG - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    WAIT_LOAD,
    SHIFT_OUT,
    DONE
  } state_t;

  // Synchronizers. SC_data goes through the same depth as SC_clk so that the
  // synced data bit is aligned with the detected synced clock edge; only the
  // clock and load strobes need a history flop for edge detection.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   clk_hist;
  logic                   load_hist;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '0;
      data_sync <= '0;
      load_sync <= '0;
      clk_hist  <= 1'b0;
      load_hist <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], SC_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], SC_data};
      load_sync <= {load_sync[SYNC_STAGES-2:0], SC_load};
      clk_hist  <= clk_sync[SYNC_STAGES-1];
      load_hist <= load_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic data_s;
  logic load_s;
  logic sclk_rise;
  logic load_rise;
  logic load_fall;

  assign sclk_s    = clk_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign load_s    = load_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~clk_hist;
  assign load_rise = load_s & ~load_hist;
  assign load_fall = ~load_s & load_hist;

  // Idle timeout: counts clki cycles with synced SC_clk low and saturates.
  // The timeout is only asserted while SC_clk is still low. The cycle that
  // sees SC_clk return high therefore carries a usable sclk_rise: that first
  // bit of a new frame would otherwise be swallowed by the saturated count.
  logic [TO_W-1:0] to_cnt;
  logic            timeout;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (sclk_s) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = ~sclk_s & (to_cnt == TO_MAX);

  // Frame FSM and datapath
  state_t               state;
  state_t               state_nxt;
  logic [DATA_LENG-1:0] in_sr;
  logic [DATA_LENG-1:0] in_sr_nxt;
  logic [DATA_LENG-1:0] out_sr;
  logic [DATA_LENG-1:0] out_sr_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     bit_cnt_nxt;
  logic [CNT_W-1:0]     cnt_inc;
  logic [DATA_LENG-1:0] cfg_nxt;
  logic                 vld_nxt;
  logic                 ferr_nxt;
  logic                 load_edge;
  logic                 take_bit;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_sr     <= '0;
      out_sr    <= '0;
      bit_cnt   <= '0;
      cfg_out   <= '0;
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_sr     <= in_sr_nxt;
      out_sr    <= out_sr_nxt;
      bit_cnt   <= bit_cnt_nxt;
      cfg_out   <= cfg_nxt;
      cfg_valid <= vld_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_sr_nxt   = in_sr;
    out_sr_nxt  = out_sr;
    bit_cnt_nxt = bit_cnt;
    cfg_nxt     = cfg_out;
    vld_nxt     = 1'b0;
    ferr_nxt    = frame_err;

    // Any load edge in the same cycle as an SC_clk rise wins; the rise is lost.
    load_edge = load_rise | load_fall;
    take_bit  = sclk_rise & ~load_s & ~load_edge;
    cnt_inc   = (state == IDLE) ? CNT_W'(1) : bit_cnt + 1'b1;

    if (timeout) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      in_sr_nxt   = '0;
      out_sr_nxt  = '0;
    end else begin
      case (state)
        IDLE, SHIFT_IN: begin
          if (load_rise) begin
            // Load arrived before a full frame: flag it, keep cfg_out.
            ferr_nxt  = 1'b1;
            state_nxt = DONE;
          end else if (take_bit) begin
            in_sr_nxt   = {data_s, in_sr[DATA_LENG-1:1]};
            bit_cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_FULL) begin
              out_sr_nxt = status_in;
              state_nxt  = WAIT_LOAD;
            end else begin
              state_nxt = SHIFT_IN;
            end
          end
        end
        WAIT_LOAD: begin
          if (load_rise) begin
            cfg_nxt     = in_sr;
            vld_nxt     = 1'b1;
            ferr_nxt    = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = SHIFT_OUT;
          end
        end
        SHIFT_OUT: begin
          if (load_fall) begin
            state_nxt = DONE;
          end else if (sclk_rise && !load_edge && bit_cnt != CNT_LAST) begin
            out_sr_nxt  = {out_sr[DATA_LENG-2:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
        DONE: begin
          // Waits for the idle timeout to re-arm.
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign data_out = ((state == WAIT_LOAD) || (state == SHIFT_OUT) || (state == DONE))
                    ? out_sr[DATA_LENG-1] : 1'b0;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sc_chain_target.sv
// Testbench for sc_chain_target: directed frames driven like the host scan
// master, with a cfg_valid scoreboard and a readback scoreboard fed from
// queues. DATA_LENG=20, IDLE_TIMEOUT=64, SC_clk half-period = 10 clki.
`timescale 1ns/1ps

module tb_sc_chain_target;

  localparam int DL = 20;

  logic          clki      = 1'b0;
  logic          rst_n     = 1'b0;
  logic          SC_clk    = 1'b0;
  logic          SC_data   = 1'b0;
  logic          SC_load   = 1'b0;
  logic [DL-1:0] status_in = '0;
  logic          data_out;
  logic [DL-1:0] cfg_out;
  logic          cfg_valid;
  logic          frame_err;
  logic          busy;

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  logic [DL-1:0] cfg_q[$];
  logic [DL-1:0] rb_q[$];

  sc_chain_target #(
    .DATA_LENG(DL),
    .SYNC_STAGES(2),
    .IDLE_TIMEOUT(64)
  ) dut (
    .clki(clki),
    .rst_n(rst_n),
    .SC_clk(SC_clk),
    .SC_data(SC_data),
    .SC_load(SC_load),
    .status_in(status_in),
    .data_out(data_out),
    .cfg_out(cfg_out),
    .cfg_valid(cfg_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clki = ~clki;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // cfg_valid monitor
  logic          vld_prev = 1'b0;
  logic [DL-1:0] exp_cfg;

  always @(negedge clki) begin
    if (vld_prev) chk("cfg_valid_width", 32'(cfg_valid), 32'd0);
    if (cfg_valid && !vld_prev) begin
      pulses++;
      if (cfg_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL cfg_valid_unexpected: got pulse with cfg_out=0x%0h, expected no pulse", cfg_out);
      end else begin
        exp_cfg = cfg_q.pop_front();
        chk("cfg_out", 32'(cfg_out), 32'(exp_cfg));
        chk("frame_err_on_load", 32'(frame_err), 32'd0);
      end
    end
    vld_prev = cfg_valid;
  end

  // Readback monitor: behaves like the master, sampling data_out on each
  // SC_clk fall while SC_load is high.
  logic          rb_active = 1'b0;
  logic          rb_first  = 1'b0;
  logic [DL-1:0] rb_word   = '0;
  logic [DL-1:0] exp_rb;
  int            rb_n = 0;

  always @(posedge SC_load) begin
    rb_active = 1'b1;
    rb_word   = '0;
    rb_n      = 0;
  end

  always @(negedge SC_clk) begin
    if (rb_active && SC_load) begin
      if (rb_n == 0) rb_first = data_out;
      rb_word = {rb_word[DL-2:0], data_out};
      rb_n++;
    end
  end

  always @(negedge SC_load) begin
    if (rb_active) begin
      rb_active = 1'b0;
      if (rb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL readback_unexpected: got word 0x%0h, expected no readback", rb_word);
      end else begin
        exp_rb = rb_q.pop_front();
        chk("readback_word", 32'(rb_word), 32'(exp_rb));
        chk("readback_first_bit", 32'(rb_first), 32'(exp_rb[DL-1]));
        chk("readback_samples", 32'(rb_n), 32'(DL));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of stimulus, expected finish");
    $fatal(1);
  end

  task automatic half();
    repeat (10) @(negedge clki);
  endtask

  // Long enough with SC_clk low for the 64-cycle timeout to re-arm the target.
  task automatic gap();
    repeat (80) @(negedge clki);
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      SC_data = bits[i];
      half();
      SC_clk = 1'b1;
      half();
      SC_clk = 1'b0;
    end
  endtask

  // SC_clk and SC_load rise together (the rise is dropped by the target), then
  // 20 falls separated by 19 rises, then SC_load drops.
  task automatic load_readback();
    half();
    SC_clk  = 1'b1;
    SC_load = 1'b1;
    half();
    for (int i = 0; i < DL; i++) begin
      SC_clk = 1'b0;
      half();
      if (i < DL - 1) begin
        SC_clk = 1'b1;
        half();
      end
    end
    SC_load = 1'b0;
    half();
    half();
  endtask

  initial begin
    repeat (3) @(negedge clki);
    chk("reset_cfg_out", 32'(cfg_out), 32'd0);
    chk("reset_cfg_valid", 32'(cfg_valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_data_out", 32'(data_out), 32'd0);
    rst_n = 1'b1;
    gap();

    // Nominal frame with readback
    status_in = 20'h81234;
    cfg_q.push_back(20'hA5C3F);
    rb_q.push_back(20'h81234);
    shift_bits(32'h000A5C3F, DL);
    load_readback();
    chk("nominal_frame_err", 32'(frame_err), 32'd0);
    chk("nominal_busy_done", 32'(busy), 32'd1);

    // Early load after 7 bits: out_sr was cleared by the re-arm, readback is 0
    gap();
    chk("rearm1_busy", 32'(busy), 32'd0);
    rb_q.push_back(20'h00000);
    shift_bits(32'h0000005A, 7);
    load_readback();
    chk("early_frame_err", 32'(frame_err), 32'd1);
    chk("early_cfg_hold", 32'(cfg_out), 32'h000A5C3F);
    chk("early_busy_done", 32'(busy), 32'd1);

    // Re-arm and a fresh frame clears frame_err
    gap();
    chk("rearm2_busy", 32'(busy), 32'd0);
    chk("rearm2_frame_err_kept", 32'(frame_err), 32'd1);
    status_in = 20'h5A5A5;
    cfg_q.push_back(20'h00001);
    rb_q.push_back(20'h5A5A5);
    shift_bits(32'h00000001, DL);
    load_readback();
    chk("rearm_frame_err_cleared", 32'(frame_err), 32'd0);

    // Over-length frame; status_in changes after capture and must not leak
    gap();
    status_in = 20'hFEDCB;
    cfg_q.push_back(20'h3C0F1);
    rb_q.push_back(20'hFEDCB);
    shift_bits(32'h0003C0F1, DL);
    status_in = 20'h0F0F0;
    shift_bits(32'h00000015, 5);
    load_readback();
    chk("overlen_frame_err", 32'(frame_err), 32'd0);

    // Reset after 10 bits
    gap();
    shift_bits(32'h000003FF, 10);
    rst_n = 1'b0;
    #1;
    chk("midrst_cfg_out", 32'(cfg_out), 32'd0);
    chk("midrst_cfg_valid", 32'(cfg_valid), 32'd0);
    chk("midrst_frame_err", 32'(frame_err), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    repeat (2) @(negedge clki);
    rst_n = 1'b1;
    gap();
    status_in = 20'h13579;
    cfg_q.push_back(20'h6B2D9);
    rb_q.push_back(20'h13579);
    shift_bits(32'h0006B2D9, DL);
    load_readback();
    gap();

    chk("cfg_valid_pulses", 32'(pulses), 32'd4);
    chk("cfg_queue_drained", 32'(cfg_q.size()), 32'd0);
    chk("readback_queue_drained", 32'(rb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
